// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: run/halt state and next-PC source select.
package pc_pkg;

   typedef enum logic {PC_RUN, PC_HALTED} pc_state_t;

   typedef enum logic [2:0] {
      SEL_RET,
      SEL_CALL,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_INC,
      SEL_HOLD
   } pc_sel_t;

   // Fixed priority: ret > call > jump > branch > increment > hold.
   function automatic pc_sel_t pick_sel(input logic ret, input logic call, input logic jump,
                                        input logic pc_src, input logic enable);
      pc_sel_t sel;
      if (ret)         sel = SEL_RET;
      else if (call)   sel = SEL_CALL;
      else if (jump)   sel = SEL_JUMP;
      else if (pc_src) sel = SEL_BRANCH;
      else if (enable) sel = SEL_INC;
      else             sel = SEL_HOLD;
      return sel;
   endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(RAS_DEPTH);

   logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
   logic [PtrW-1:0]   r_top_ptr;
   logic [CntW-1:0]   r_count;
   logic [PtrW-1:0]   w_push_ptr;

   assign w_push_ptr = r_top_ptr + 1'b1;
   assign empty      = (r_count == '0);
   assign full       = (r_count == FullCount);
   assign top        = r_mem[r_top_ptr];
   assign overflow   = push & full;
   assign underflow  = pop & ~push & empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_top_ptr <= '1;
         r_count   <= '0;
      end else if (push) begin
         r_top_ptr <= w_push_ptr;
         if (!full) r_count <= r_count + 1'b1;
      end else if (pop && !empty) begin
         r_top_ptr <= r_top_ptr - 1'b1;
         r_count   <= r_count - 1'b1;
      end
   end

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push) r_mem[w_push_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC priority mux, return-address stack and sticky halt state.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 5,
   parameter int unsigned       RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              pc_src,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt,
   input  logic              resume,
   output logic [ADDR_W-1:0] curr_inst_addr,
   output logic              halted,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_error
);

   pc_state_t         r_state;
   pc_state_t         w_state_next;
   pc_sel_t           w_sel;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_active;
   logic              w_push;
   logic              w_pop;
   logic              w_overflow;
   logic              w_underflow;
   logic              r_ras_error;

   // Nothing architectural moves in a halt-entry cycle, while halted, or in the resume cycle.
   assign w_active = (r_state == PC_RUN) && !halt;
   assign w_sel    = pick_sel(ret, call, jump, pc_src, enable);
   assign w_pc_inc = r_pc + 1'b1;
   assign w_push   = w_active && (w_sel == SEL_CALL);
   assign w_pop    = w_active && (w_sel == SEL_RET);

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_pc_inc),
      .top       (w_ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (w_overflow),
      .underflow (w_underflow)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= PC_RUN;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         PC_RUN:    if (halt) w_state_next = PC_HALTED;
         PC_HALTED: if (resume && !halt) w_state_next = PC_RUN;
         default:   w_state_next = PC_RUN;
      endcase
   end

   always_comb begin
      halted = (r_state == PC_HALTED);
   end

   always_comb begin
      w_pc_next = r_pc;
      if (w_active) begin
         case (w_sel)
            SEL_RET:    w_pc_next = ras_empty ? w_pc_inc : w_ras_top;
            SEL_CALL:   w_pc_next = jump_target;
            SEL_JUMP:   w_pc_next = jump_target;
            SEL_BRANCH: w_pc_next = branch_target;
            SEL_INC:    w_pc_next = w_pc_inc;
            default:    w_pc_next = r_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= RESET_ADDR;
         r_ras_error <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if (w_overflow || w_underflow) r_ras_error <= 1'b1;
      end
   end

   assign curr_inst_addr = r_pc;
   assign ras_error      = r_ras_error;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle MIPS core. It holds the instruction address and selects the next value from sequential increment, branch, jump, call or return. It contains a small return-address stack (RAS) for call/return pairs and a sticky halt state machine. It sits between the control/branch logic and instruction-memory addressing.

## Interface
Parameters:
- ADDR_W, 5, instruction word-address width; the PC counts words.
- RAS_DEPTH, 4, number of return-address entries; must be a power of two, ≥2.
- RESET_ADDR, 0, value loaded into the PC on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  sequential-advance enable; low means stall.
- pc_src  in  1  branch taken; next PC = branch_target.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  unconditional jump to jump_target.
- call  in  1  jump to jump_target and push curr_inst_addr+1.
- ret  in  1  pop the RAS top into the PC.
- jump_target  in  ADDR_W  jump/call destination.
- halt  in  1  enter the HALTED state.
- resume  in  1  leave HALTED; the PC is unchanged.
- curr_inst_addr  out  ADDR_W  registered current PC.
- halted  out  1  high while in HALTED.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_error  out  1  sticky flag: a RAS overflow or underflow has occurred.

## Operation
- States: RUN and HALTED.
  - RUN→HALTED when halt=1. In that cycle the PC, the RAS and ras_error do not update.
  - HALTED→RUN when resume=1 and halt=0. In that cycle the PC and the RAS still do not update.
  - While HALTED, all redirect and enable inputs are ignored.
- Next-PC priority in RUN, highest first:
  - ret: PC ← RAS top, pop.
  - call: PC ← jump_target, push curr+1.
  - jump: PC ← jump_target.
  - pc_src: PC ← branch_target.
  - enable: PC ← curr+1.
  - otherwise: hold.
- Redirects (ret, call, jump, pc_src) take effect even when enable=0.
- Arithmetic: curr+1 is modulo 2^ADDR_W; the maximum address wraps to 0.
- Pushed return addresses wrap the same way.
- RAS overflow: a call while full overwrites the oldest entry (circular buffer). Count stays RAS_DEPTH and ras_error is set.
- RAS underflow: a ret while empty gives PC ← curr+1, leaves the count at 0 and sets ras_error.
- Only the highest-priority request acts. A lower-priority call is neither pushed nor counted.
- ras_error clears only on reset.

## Timing
- One-cycle latency: inputs are sampled at posedge N, and the new curr_inst_addr is visible after posedge N.
- All outputs are registered or decoded from registers. There are no combinational input→output paths.
- Reset asserted at any time, including mid-call or while HALTED, gives immediately:
  - curr_inst_addr=RESET_ADDR, state RUN, halted=0;
  - RAS count 0, ras_empty=1, ras_full=0, ras_error=0.
- RAS contents are don't-care after reset.
- Release of reset_n is assumed synchronous to clk. The first update happens at the first posedge with reset_n=1.
- ras_empty and ras_full reflect the count after the current edge.

## Structure
- Package pc_pkg holds:
  - the state enum pc_state_t {PC_RUN, PC_HALTED};
  - the next-PC select enum pc_sel_t {SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_INC, SEL_HOLD}.
- Sub-module ras_stack, parametrised by ADDR_W and RAS_DEPTH. It has:
  - inputs push, pop and push_data;
  - outputs top, empty, full, overflow and underflow pulses.
  - It is a circular storage array with a $clog2(RAS_DEPTH)-bit top pointer and a count.
- pc_unit contains the next-PC mux, the PC register, the state register and the sticky ras_error flag.

## Test plan
- Reset and increment: hold reset_n=0, then release with enable=1 for 3 cycles → PC reads 0,1,2,3. Assert reset_n=0 mid-run → PC is 0 immediately.
- Wrap and stall: with ADDR_W=5 and PC=31, enable=1 → PC=0. With enable=0 and pc_src=1, branch_target=9 → PC=9. With enable=0 and no redirect → PC holds.
- Priority: pc_src=1, jump=1, jump_target=20, branch_target=7 → PC=20. Then ret=1 and call=1 together with the RAS holding 12 → PC=12, and nothing is pushed.
- Call/return nesting: at PC=3, call to 10; at PC=10, call to 16; ret; ret → PC sequence 10,16,11,4, ending with ras_empty=1 and ras_error=0.
- RAS boundaries: 5 nested calls with RAS_DEPTH=4 → ras_full=1, ras_error=1, and the 4 rets return the last 4 return addresses. A further ret while empty → PC=curr+1.
- Halt: halt=1 at PC=6 → halted=1 next cycle and PC stays 6 despite enable, jump and call inputs. Then resume=1 → halted=0, PC still 6, and it increments from the following cycle.
